truth_table_capture: RTL and testbench

//   Hardware counterpart of a directed truth-table bench. Drives every input

---
 rtl/tt_pkg.sv | 15 +
 rtl/tt_settle_timer.sv | 37 +++
 rtl/truth_table_capture.sv | 159 +++++++++++++++
 tb/tb_truth_table_capture.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table capture block: FSM state encoding
// and default sweep geometry.
package tt_pkg;

  localparam int DEF_N_IN   = 3;
  localparam int DEF_SETTLE = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle counter for one vector: load clears, en counts up, expire flags the
// final settle cycle (count == SETTLE-1).
module tt_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  // Wide enough to hold SETTLE, since the expiring cycle still counts once.
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CW'(SETTLE - 1));

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps every input vector through a lab circuit, captures its truth table and
// compares it against EXPECTED. Optional outputs under TT_MAXTERM_OUT_EN.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int                      N_IN     = DEF_N_IN,
  parameter int                      SETTLE   = DEF_SETTLE,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED = 8'b1011_0010
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [N_IN-1:0]        p,
  input  logic                   led,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   tt,
  output logic                   match,
`ifdef TT_MAXTERM_OUT_EN
  output logic [(1<<N_IN)-1:0]   maxterms,
  output logic [N_IN:0]          zero_cnt,
`endif
  output logic [N_IN-1:0]        first_fail
);

  localparam int TW = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TW - 1);

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] p_q, p_d;
  logic [TW-1:0]   tt_q, tt_d;
  logic            match_q, match_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic [TW-1:0]   diff;
  logic            tmr_load, tmr_en, tmr_expire;
`ifdef TT_MAXTERM_OUT_EN
  logic [TW-1:0]   maxt_q, maxt_d;
  logic [N_IN:0]   zeros_q, zeros_d;
`endif

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (tmr_load),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    p_d      = p_q;
    tt_d     = tt_q;
    match_d  = match_q;
    ff_d     = ff_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    diff     = '0;
`ifdef TT_MAXTERM_OUT_EN
    maxt_d   = maxt_q;
    zeros_d  = zeros_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          idx_d    = '0;
          p_d      = '0;
          tt_d     = '0;
          match_d  = 1'b0;
          ff_d     = '0;
          tmr_load = 1'b1;
`ifdef TT_MAXTERM_OUT_EN
          maxt_d   = '0;
          zeros_d  = '0;
`endif
        end
      end
      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        tt_d[idx_q] = led;
        if (idx_q == LAST_IDX) begin
          // Verdict uses the table including this last sample so it is valid in DONE.
          state_d = ST_DONE;
          diff    = tt_d ^ EXPECTED;
          match_d = (diff == '0);
          ff_d    = '0;
          for (int i = TW - 1; i >= 0; i--) begin
            if (diff[i]) begin
              ff_d = N_IN'(i);
            end
          end
`ifdef TT_MAXTERM_OUT_EN
          maxt_d  = ~tt_d;
          zeros_d = '0;
          for (int i = 0; i < TW; i++) begin
            zeros_d = zeros_d + (N_IN + 1)'(~tt_d[i]);
          end
`endif
        end else begin
          state_d  = ST_SETTLE;
          idx_d    = idx_q + 1'b1;
          p_d      = idx_q + 1'b1;
          tmr_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      p_q     <= '0;
      tt_q    <= '0;
      match_q <= 1'b0;
      ff_q    <= '0;
`ifdef TT_MAXTERM_OUT_EN
      maxt_q  <= '0;
      zeros_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
      tt_q    <= tt_d;
      match_q <= match_d;
      ff_q    <= ff_d;
`ifdef TT_MAXTERM_OUT_EN
      maxt_q  <= maxt_d;
      zeros_q <= zeros_d;
`endif
    end
  end

  assign p          = p_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign tt         = tt_q;
  assign match      = match_q;
  assign first_fail = ff_q;
`ifdef TT_MAXTERM_OUT_EN
  assign maxterms   = maxt_q;
  assign zero_cnt   = zeros_q;
`endif

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: table of circuit models with
// hand-computed verdicts, plus reset-abort, start-filtering and start-hold runs.
module tb_truth_table_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] p;
  logic       led;
  logic       busy, done, match;
  logic [7:0] tt;
  logic [2:0] first_fail;
`ifdef TT_MAXTERM_OUT_EN
  logic [7:0] maxterms;
  logic [3:0] zero_cnt;
`endif

  logic [7:0] model_tt = 8'b1011_0010;
  logic       strict = 1'b0;
  logic       led_drv = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Circuit model: led = model_tt[p]; in strict mode the bench inverts it on
  // every cycle except the last of each vector, so only the right sample point works.
  assign led = strict ? led_drv : model_tt[p];

  always #5 clk = ~clk;

  truth_table_capture dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .p          (p),
    .led        (led),
    .busy       (busy),
    .done       (done),
    .tt         (tt),
    .match      (match),
`ifdef TT_MAXTERM_OUT_EN
    .maxterms   (maxterms),
    .zero_cnt   (zero_cnt),
`endif
    .first_fail (first_fail)
  );

  typedef struct {
    logic [7:0] model;
    logic [7:0] exp_tt;
    logic       exp_match;
    logic [2:0] exp_ff;
    logic [7:0] exp_max;
    logic [3:0] exp_zeros;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulses (or holds) start, accepts it, and runs until done or a 100-cycle bound.
  // lat counts edges after the accept edge; checks p against the vector schedule.
  task automatic run_sweep(input bit pulse, input bit hold, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    while (1) begin
      start   = hold ? 1'b1 : (pulse && (lat % 5 == 2));
      led_drv = model_tt[p] ^ (lat % 3 != 2);
      if (lat < 24) check("p_schedule", {29'd0, p}, lat / 3);
      @(posedge clk);
      lat++;
      #1;
      if (done || lat >= 100) break;
    end
    if (!hold) start = 1'b0;
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input vec_t v, input int lat);
    check("latency", lat, 24);
    check("done_pulse", {31'd0, done}, 1);
    check("busy_in_done", {31'd0, busy}, 1);
    check("tt", {24'd0, tt}, {24'd0, v.exp_tt});
    check("match", {31'd0, match}, {31'd0, v.exp_match});
    check("first_fail", {29'd0, first_fail}, {29'd0, v.exp_ff});
`ifdef TT_MAXTERM_OUT_EN
    check("maxterms", {24'd0, maxterms}, {24'd0, v.exp_max});
    check("zero_cnt", {28'd0, zero_cnt}, {28'd0, v.exp_zeros});
`endif
  endtask

  initial begin
    int lat;
    vecs[0] = '{8'b1011_0010, 8'b1011_0010, 1'b1, 3'd0, 8'b0100_1101, 4'd4};
    vecs[1] = '{8'b1001_0010, 8'b1001_0010, 1'b0, 3'd5, 8'b0110_1101, 4'd5};
    vecs[2] = '{8'b0000_0000, 8'b0000_0000, 1'b0, 3'd1, 8'b1111_1111, 4'd8};
    vecs[3] = '{8'b1111_1111, 8'b1111_1111, 1'b0, 3'd0, 8'b0000_0000, 4'd0};
    vecs[4] = '{8'b0011_0010, 8'b0011_0010, 1'b0, 3'd7, 8'b1100_1101, 4'd5};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_p", {29'd0, p}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_tt", {24'd0, tt}, 0);
    check("rst_match", {31'd0, match}, 0);
    check("rst_ff", {29'd0, first_fail}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Table of circuit models; odd entries use the strict sample-point model
    for (int i = 0; i < 5; i++) begin
      model_tt = vecs[i].model;
      strict   = (i % 2 == 1);
      run_sweep(1'b0, 1'b0, lat);
      check_result(vecs[i], lat);
      $display("vec %0d: model=%b tt=%b match=%0d first_fail=%0d latency=%0d",
               i, vecs[i].model, tt, match, first_fail, lat);
      @(posedge clk);
      #1;
      check("done_one_cycle", {31'd0, done}, 0);
      check("busy_after", {31'd0, busy}, 0);
      check("tt_held", {24'd0, tt}, {24'd0, vecs[i].exp_tt});
      check("match_held", {31'd0, match}, {31'd0, vecs[i].exp_match});
      strict = 1'b0;
    end

    // Reset while idx == 4 aborts the sweep
    model_tt = 8'b1011_0010;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (p != 3'd4 && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("reach_idx4", {29'd0, p}, 4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_p", {29'd0, p}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_tt", {24'd0, tt}, 0);
    $display("reset abort: p=%0d busy=%0d tt=%b", p, busy, tt);
    run_sweep(1'b0, 1'b0, lat);
    check_result(vecs[0], lat);
    $display("sweep after abort: tt=%b match=%0d latency=%0d", tt, match, lat);
    @(posedge clk);
    #1;

    // start pulsed repeatedly during a sweep is ignored
    model_tt = 8'b1001_0010;
    run_sweep(1'b1, 1'b0, lat);
    check_result(vecs[1], lat);
    $display("start pulsed mid-sweep: tt=%b latency=%0d", tt, lat);
    @(posedge clk);
    #1;
    check("no_restart", {31'd0, busy}, 0);
    @(posedge clk);
    #1;
    check("no_queued_start", {31'd0, busy}, 0);

    // start held high: next sweep is accepted in the idle cycle after DONE
    model_tt = 8'b0000_0000;
    run_sweep(1'b0, 1'b1, lat);
    check_result(vecs[2], lat);
    @(posedge clk);
    #1;
    check("hold_idle_busy", {31'd0, busy}, 0);
    check("hold_idle_done", {31'd0, done}, 0);
    model_tt = 8'b1011_0010;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("hold_restart_busy", {31'd0, busy}, 1);
    check("hold_restart_tt_clear", {24'd0, tt}, 0);
    check("hold_restart_match_clear", {31'd0, match}, 0);
    wait_done(lat);
    check_result(vecs[0], lat);
    $display("start held: second sweep tt=%b match=%0d latency=%0d", tt, match, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
